// File: rtl/updown_counter_8bit.sv
// updown_counter_8bit: synchronous loadable up/down counter with ripple-carry out
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset, clears the count
//   en_i   count enable, gates up/down only
//   s_i    mode: 00 clear, 01 down, 10 load, 11 up
//   in_i   parallel load data
//   out_o  registered count
//   rco_o  terminal-count flag, high the cycle before an enabled wrap
module updown_counter_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       s_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             rco_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = s_i == 2'b00 ? '0 :
            s_i == 2'b10 ? in_i :
            !en_i        ? cnt_q :
            s_i == 2'b11 ? cnt_q + WIDTH'(1) :
            s_i == 2'b01 ? cnt_q - WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign out_o = cnt_q;
  assign rco_o = en_i & ((s_i == 2'b11 & (&cnt_q)) | (s_i == 2'b01 & (cnt_q == '0)));
endmodule

// File: tb/tb_updown_counter_8bit.sv
// tb_updown_counter_8bit: directed table-driven checks of the up/down counter
module tb_updown_counter_8bit;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] s;
  logic [7:0] din, dout;
  logic       rco;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] s;
    logic       en;
    logic [7:0] din;
    logic       exp_rco;
    logic [7:0] exp_out;
  } vec_t;
  vec_t vecs[$];
  updown_counter_8bit #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .s_i(s), .in_i(din), .out_o(dout), .rco_o(rco)
  );
  always #5 clk = ~clk;
  task automatic chk_out(input string name, input logic [7:0] exp);
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL %s: out=%h expected %h", name, dout, exp);
    end
  endtask
  task automatic chk_rco(input string name, input logic exp);
    checks++;
    if (rco !== exp) begin
      errors++;
      $display("FAIL %s: rco=%b expected %b (out=%h)", name, rco, exp, dout);
    end
  endtask
  task automatic step(input logic r, input logic [1:0] sm, input logic e, input logic [7:0] d);
    rst = r; s = sm; en = e; din = d;
    #1;
  endtask
  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(1'b1, 2'b11, 1'b1, 8'h00);
    edge_settle();
    edge_settle();
    chk_out("reset", 8'h00);
    chk_rco("reset_rco", 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b11, 1'b1, 8'h00);
      chk_rco("up20_rco", 1'b0);
      edge_settle();
    end
    chk_out("up20", 8'h14);
    vecs.push_back('{"load_fe",   1'b0, 2'b10, 1'b1, 8'hFE, 1'b0, 8'hFE});
    vecs.push_back('{"up_ff",     1'b0, 2'b11, 1'b1, 8'h00, 1'b0, 8'hFF});
    vecs.push_back('{"up_wrap",   1'b0, 2'b11, 1'b1, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{"up_01",     1'b0, 2'b11, 1'b1, 8'h00, 1'b0, 8'h01});
    vecs.push_back('{"clear",     1'b0, 2'b00, 1'b1, 8'h77, 1'b0, 8'h00});
    vecs.push_back('{"dn_wrap",   1'b0, 2'b01, 1'b1, 8'h00, 1'b1, 8'hFF});
    vecs.push_back('{"dn_fe",     1'b0, 2'b01, 1'b1, 8'h00, 1'b0, 8'hFE});
    vecs.push_back('{"load_96",   1'b0, 2'b10, 1'b0, 8'h96, 1'b0, 8'h96});
    vecs.push_back('{"up_97",     1'b0, 2'b11, 1'b1, 8'h00, 1'b0, 8'h97});
    vecs.push_back('{"dn_96",     1'b0, 2'b01, 1'b1, 8'h00, 1'b0, 8'h96});
    vecs.push_back('{"dn_95",     1'b0, 2'b01, 1'b1, 8'h00, 1'b0, 8'h95});
    vecs.push_back('{"load_ff",   1'b0, 2'b10, 1'b1, 8'hFF, 1'b0, 8'hFF});
    vecs.push_back('{"ld_at_ff",  1'b0, 2'b10, 1'b1, 8'hFF, 1'b0, 8'hFF});
    vecs.push_back('{"hold_ff",   1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'hFF});
    vecs.push_back('{"dn_ff_fe",  1'b0, 2'b01, 1'b1, 8'h00, 1'b0, 8'hFE});
    vecs.push_back('{"clr_noen",  1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{"hold_00",   1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{"up_noen",   1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{"load_32",   1'b0, 2'b10, 1'b1, 8'h32, 1'b0, 8'h32});
    vecs.push_back('{"up_33",     1'b0, 2'b11, 1'b1, 8'h00, 1'b0, 8'h33});
    vecs.push_back('{"rst_mid",   1'b1, 2'b11, 1'b1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{"up_after",  1'b0, 2'b11, 1'b1, 8'h00, 1'b0, 8'h01});
    vecs.push_back('{"load_ff2",  1'b0, 2'b10, 1'b1, 8'hFF, 1'b0, 8'hFF});
    vecs.push_back('{"rst_at_ff", 1'b1, 2'b11, 1'b1, 8'h00, 1'b1, 8'h00});
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].s, vecs[i].en, vecs[i].din);
      chk_rco(vecs[i].name, vecs[i].exp_rco);
      edge_settle();
      chk_out(vecs[i].name, vecs[i].exp_out);
    end
    step(1'b0, 2'b10, 1'b1, 8'h40);
    edge_settle();
    chk_out("load_40", 8'h40);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b11, 1'b0, 8'h00);
      chk_rco("hold_up_rco", 1'b0);
      edge_settle();
    end
    chk_out("hold_up", 8'h40);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b01, 1'b0, 8'h00);
      chk_rco("hold_dn_rco", 1'b0);
      edge_settle();
    end
    chk_out("hold_dn", 8'h40);
    step(1'b0, 2'b00, 1'b0, 8'h00);
    edge_settle();
    chk_out("clear_en0", 8'h00);
    chk_rco("clear_en0_rco", 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
